regfile_multiport: RTL
======================

// Module: regfile_multiport
// PURPOSE
//   Parametrised integer register file: NRD combinational read ports, one write port,
//   optional hardwired-zero entry 0, optional write-to-read bypass.
//   Data array has no per-bit reset. A clear FSM zeroes the array one entry per cycle
//   after reset or on request, so the array stays RAM-inferable.
//   Sits in the core decode/writeback path; also used by the multi-issue core (NRD=4).
// PARAMETERS
//   XLEN      32  data width of each entry
//   NREG      32  number of entries (power of two, >=2); AW = $clog2(NREG) is a localparam
//   NRD        2  number of read ports (>=1)
//   ZERO_REG   1  1: entry 0 reads as 0 and ignores writes; 0: entry 0 is an ordinary register
//   BYPASS     1  1: a same-cycle write to a read address is forwarded to that read port
// PORTS
//   clk      in   1         clock; all state updates on the rising edge
//   rst      in   1         synchronous, active-high reset
//   ra       in   NRD*AW    read addresses; port k = ra[k*AW +: AW]
//   rd       out  NRD*XLEN  read data; port k = rd[k*XLEN +: XLEN]
//   wa       in   AW        write address
//   wd       in   XLEN      write data
//   wen      in   1         write enable
//   clr_req  in   1         request a full array clear (1-cycle pulse is sufficient)
//   ready    out  1         1: IDLE, reads and writes valid; 0: clear in progress
// BEHAVIOUR
//   Reset (rst=1 at an edge): state<=CLEAR, cnt<=0. While rst is high: ready=0, all rd=0.
//   FSM states:
//     IDLE  - clr_req=1 -> CLEAR, cnt<=0.
//     CLEAR - each edge: mem[cnt]<=0, cnt<=cnt+1.
//             cnt==NREG-1 -> IDLE (last entry is written on the same edge).
//   Clear latency: ready=1 exactly NREG edges after the first edge with rst=0.
//   rst during CLEAR restarts the clear at cnt=0. clr_req during CLEAR is ignored, not queued.
//   Write: on an edge in IDLE with wen=1 -> mem[wa]<=wd.
//     Dropped when ZERO_REG=1 and wa==0. wen is ignored in CLEAR.
//   wen and clr_req in the same IDLE cycle: the write commits on that edge.
//     The clear then overwrites it, so the net result is all zero.
//   Read (combinational, port k, priority top-down):
//     - ready==0                                      -> 0
//     - ZERO_REG && ra_k==0                           -> 0
//     - BYPASS && wen && wa==ra_k                     -> wd
//     - otherwise                                     -> mem[ra_k]
//     Without BYPASS, a read of the written address returns the old value until the edge.
//   Multiple read ports may address the same entry. Each port resolves independently.
//   cnt is AW+1 bits wide, so NREG-1 is compared without wrap. Addresses are exactly AW
//   bits; out-of-range addresses are not possible.
//   No X may reach rd after ready=1: every entry is written by the clear first.
// STRUCTURE
//   Shared package rf_pkg: FSM state enum (RF_IDLE, RF_CLEAR) and
//   function rf_aw(nreg) = $clog2(nreg), reused by the hazard unit.
//   Sub-module regfile_clear_fsm: owns state, cnt and ready, and outputs the clear
//   address/enable. The top module muxes the write port between the core and the FSM,
//   and instantiates NRD read muxes in a generate loop.
// TESTING (defaults unless stated)
//   1. rst=1 for 3 cycles, then 0 -> ready=0 for 32 edges, 1 on edge 32; all rd=0 throughout.
//   2. Write x5=0xDEADBEEF, then ra0=5, ra1=5 -> both rd=0xDEADBEEF.
//      Write x0=0x1234, read x0 -> 0.
//   3. BYPASS=1: wen=1, wa=7, wd=0xA5A5A5A5, ra1=7 in the same cycle
//      -> rd1=0xA5A5A5A5 before the edge.
//      BYPASS=0: rd1 shows the old value, then the new value after the edge.
//   4. Fill x1..x31 with i, pulse clr_req -> ready=0 for 32 cycles, then all reads 0.
//      A wen issued during the clear is not committed.
//   5. Assert rst at cnt=10 mid-clear -> restart; ready rises 32 edges after rst drops.
//      clr_req+wen same cycle -> target entry reads 0 after the clear.
//   6. ZERO_REG=0, NREG=16, NRD=4: write x0=7 -> reads 7; 4 ports at distinct
//      addresses all correct.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the integer register file and its clients.
//   rf_state_e : state encoding of the array-clear FSM
//   rf_aw()    : address width for a register file of nreg entries
package rf_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    function automatic int rf_aw(input int nreg);
        return $clog2(nreg);
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Array-clear sequencer for regfile_multiport.
// After reset, or after a clear request while idle, it walks every entry
// index once and asks the parent to write zero there. It then reports ready.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset; restarts the clear at entry 0
//   clr_req_i  in   clear request; honoured only while idle
//   clr_we_o   out  write-zero enable for the array
//   clr_addr_o out  entry index being cleared
//   ready_o    out  1 when idle (array contents valid), forced 0 while rst is high
module regfile_clear_fsm
    import rf_pkg::*;
#(
    parameter  int NREG = 32,
    localparam int AW   = rf_aw(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req_i,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o,
    output logic          ready_o
);

    // The counter is one bit wider than an address, so the last index
    // compares cleanly without wrapping back to zero.
    localparam int unsigned CNT_LAST_I = NREG - 1;
    localparam logic [AW:0] CNT_LAST   = CNT_LAST_I[AW:0];
    localparam logic [AW:0] CNT_ONE    = {{AW{1'b0}}, 1'b1};

    rf_state_e   state_q;
    logic [AW:0] cnt_q;
    logic        ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                RF_IDLE: begin
                    if (clr_req_i) begin
                        state_q <= RF_CLEAR;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                RF_CLEAR: begin
                    // The last entry is written on the same edge that returns to idle.
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= RF_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= RF_CLEAR;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Gating with rst keeps ready low before the first reset edge has loaded
    // the registers, and suppresses clear writes through an unknown counter.
    assign clr_we_o   = (state_q == RF_CLEAR) && !rst;
    assign clr_addr_o = cnt_q[AW-1:0];
    assign ready_o    = ready_q && !rst;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised integer register file: NRD combinational read ports, one
// write port, optional hardwired-zero entry 0, optional write-to-read bypass.
// The data array has no reset; regfile_clear_fsm zeroes it one entry per
// cycle after reset or on request, so the array remains RAM-inferable.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   ra       in   NRD*AW read addresses, port k = ra[k*AW +: AW]
//   rd       out  NRD*XLEN read data, port k = rd[k*XLEN +: XLEN]
//   wa       in   write address
//   wd       in   write data
//   wen      in   write enable (ignored while clearing)
//   clr_req  in   request a full array clear
//   ready    out  1: idle, reads/writes valid; 0: clear in progress
module regfile_multiport
    import rf_pkg::*;
#(
    parameter  int XLEN     = 32,
    parameter  int NREG     = 32,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = rf_aw(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                wen,
    input  logic                clr_req,
    output logic                ready
);

    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            core_we;
    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [XLEN-1:0] mem_wd;

    logic [XLEN-1:0] mem_q [NREG];

    regfile_clear_fsm #(
        .NREG (NREG)
    ) u_clear_fsm (
        .clk        (clk),
        .rst        (rst),
        .clr_req_i  (clr_req),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .ready_o    (ready)
    );

    // Core writes only land while idle; entry 0 is read-only when hardwired.
    assign core_we = ready && wen && !((ZERO_REG != 0) && (wa == '0));

    // clr_we and ready are never high together, so the clear simply owns the
    // single write port whenever it is active.
    assign mem_we = clr_we || core_we;
    assign mem_wa = clr_we ? clr_addr : wa;
    assign mem_wd = clr_we ? '0 : wd;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra_k;
        logic [XLEN-1:0] rd_k;

        assign ra_k = ra[k*AW +: AW];

        always_comb begin
            if (!ready) begin
                rd_k = '0;
            end else if ((ZERO_REG != 0) && (ra_k == '0)) begin
                rd_k = '0;
            end else if ((BYPASS != 0) && wen && (wa == ra_k)) begin
                rd_k = wd;
            end else begin
                rd_k = mem_q[ra_k];
            end
        end

        assign rd[k*XLEN +: XLEN] = rd_k;
    end

endmodule
